// File: rtl/modrm_pkg.sv
// Shared constants and FSM state type for the sequenced ModRM EA generator.
// Register select bit positions, mod encodings, direct-address rm, state enum.
package modrm_pkg;

    localparam int REG_DI = 0;
    localparam int REG_SI = 2;
    localparam int REG_BP = 4;
    localparam int REG_BX = 8;

    localparam logic [1:0] MOD_NODISP = 2'b00;
    localparam logic [1:0] MOD_D8     = 2'b01;
    localparam logic [1:0] MOD_D16    = 2'b10;
    localparam logic [1:0] MOD_REG    = 2'b11;

    localparam logic [2:0] RM_DIRECT = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        BASE,
        INDEX,
        DISP0,
        DISP1,
        DONE
    } ea_state_t;

endpackage

// File: rtl/modrm_ea_decode.sv
// Combinational ModRM decode: mod,rm -> base/index one-hot selects,
// has_index, disp_bytes (0/1/2), is_direct, uses_bp (BP-based address).
module modrm_ea_decode
    import modrm_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic [1:0]      mod,
    input  logic [2:0]      rm,
    output logic [NREG-1:0] base,
    output logic [NREG-1:0] index,
    output logic            has_index,
    output logic [1:0]      disp_bytes,
    output logic            is_direct,
    output logic            uses_bp
);

    always_comb begin
        base      = '0;
        index     = '0;
        has_index = 1'b0;
        is_direct = (mod == MOD_NODISP) &&
                    (rm == RM_DIRECT);
        unique case (rm)
            3'b000: begin
                base[REG_BX]  = 1'b1;
                index[REG_SI] = 1'b1;
                has_index     = 1'b1;
            end
            3'b001: begin
                base[REG_BX]  = 1'b1;
                index[REG_DI] = 1'b1;
                has_index     = 1'b1;
            end
            3'b010: begin
                base[REG_BP]  = 1'b1;
                index[REG_SI] = 1'b1;
                has_index     = 1'b1;
            end
            3'b011: begin
                base[REG_BP]  = 1'b1;
                index[REG_DI] = 1'b1;
                has_index     = 1'b1;
            end
            3'b100: base[REG_SI] = 1'b1;
            3'b101: base[REG_DI] = 1'b1;
            3'b110: base[REG_BP] = !is_direct;
            3'b111: base[REG_BX] = 1'b1;
            default: base = '0;
        endcase
    end

    always_comb begin
        unique case (mod)
            MOD_D8:     disp_bytes = 2'd1;
            MOD_D16:    disp_bytes = 2'd2;
            MOD_NODISP: disp_bytes = is_direct ? 2'd2 : 2'd0;
            default:    disp_bytes = 2'd0;
        endcase
    end

    assign uses_bp = (rm == 3'b010) || (rm == 3'b011) ||
                     ((rm == RM_DIRECT) && (mod != MOD_NODISP));

endmodule

// File: rtl/modrm_ea_seq.sv
// Sequenced 8086 ModRM effective-address generator (decode stage).
// Ports: in_* ModRM handshake, rsel/rdata RF read, disp_* byte
// handshake, ea_* result handshake, flush abort. EA_SEG_SEL_EN adds seg_ss.
module modrm_ea_seq
    import modrm_pkg::*;
#(
    parameter int AW   = 16,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_modrm,
    output logic [NREG-1:0] rsel,
    input  logic [AW-1:0]   rdata,
    input  logic            disp_valid,
    output logic            disp_ready,
    input  logic [7:0]      disp_byte,
    output logic            ea_valid,
    input  logic            ea_ready,
    output logic [AW-1:0]   ea,
    output logic            ea_is_reg,
`ifdef EA_SEG_SEL_EN
    output logic            seg_ss,
`endif
    output logic [2:0]      ea_rm
);

    ea_state_t       state;
    logic [1:0]      mod_q;
    logic [7:0]      lo_q;
    logic [AW-1:0]   acc;

    logic [1:0]      dmod;
    logic [2:0]      drm;
    logic [NREG-1:0] base_sel;
    logic [NREG-1:0] index_sel;
    logic            has_index;
    logic [1:0]      disp_bytes;
    logic            is_direct;
    logic            uses_bp;
    logic            has_disp;

    logic [AW-1:0]   sum_reg;
    logic [AW-1:0]   sum_d8;
    logic [AW-1:0]   sum_d16;

    // Decode the live byte while idle, the latched one afterwards.
    assign dmod = (state == IDLE) ? in_modrm[7:6] : mod_q;
    assign drm  = (state == IDLE) ? in_modrm[2:0] : ea_rm;

    modrm_ea_decode #(
        .NREG(NREG)
    ) u_dec (
        .mod        (dmod),
        .rm         (drm),
        .base       (base_sel),
        .index      (index_sel),
        .has_index  (has_index),
        .disp_bytes (disp_bytes),
        .is_direct  (is_direct),
        .uses_bp    (uses_bp)
    );

    assign has_disp = (disp_bytes != 2'd0);
    assign sum_reg  = acc + rdata;
    assign sum_d8   = acc + AW'($signed(disp_byte));
    assign sum_d16  = acc + AW'($signed({disp_byte, lo_q}));

    logic unused_reg_field;
    assign unused_reg_field = ^in_modrm[5:3];
`ifndef EA_SEG_SEL_EN
    logic unused_bp;
    assign unused_bp = uses_bp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            rsel       <= '0;
            disp_ready <= 1'b0;
            ea_valid   <= 1'b0;
            ea         <= '0;
            ea_is_reg  <= 1'b0;
            ea_rm      <= '0;
            mod_q      <= '0;
            lo_q       <= '0;
            acc        <= '0;
`ifdef EA_SEG_SEL_EN
            seg_ss     <= 1'b0;
`endif
        end else if (flush) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            rsel       <= '0;
            disp_ready <= 1'b0;
            ea_valid   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mod_q     <= in_modrm[7:6];
                        ea_rm     <= in_modrm[2:0];
                        acc       <= '0;
                        in_ready  <= 1'b0;
                        ea_is_reg <= (dmod == MOD_REG);
`ifdef EA_SEG_SEL_EN
                        seg_ss    <= uses_bp &&
                                     (dmod != MOD_REG);
`endif
                        if (dmod == MOD_REG) begin
                            state    <= DONE;
                            ea       <= '0;
                            ea_valid <= 1'b1;
                        end else if (is_direct) begin
                            state      <= DISP0;
                            disp_ready <= 1'b1;
                        end else begin
                            state <= BASE;
                            rsel  <= base_sel;
                        end
                    end
                end
                BASE: begin
                    acc <= rdata;
                    if (has_index) begin
                        state <= INDEX;
                        rsel  <= index_sel;
                    end else begin
                        rsel <= '0;
                        if (has_disp) begin
                            state      <= DISP0;
                            disp_ready <= 1'b1;
                        end else begin
                            state    <= DONE;
                            ea       <= rdata;
                            ea_valid <= 1'b1;
                        end
                    end
                end
                INDEX: begin
                    acc  <= sum_reg;
                    rsel <= '0;
                    if (has_disp) begin
                        state      <= DISP0;
                        disp_ready <= 1'b1;
                    end else begin
                        state    <= DONE;
                        ea       <= sum_reg;
                        ea_valid <= 1'b1;
                    end
                end
                DISP0: begin
                    if (disp_valid) begin
                        if (mod_q == MOD_D8) begin
                            acc        <= sum_d8;
                            ea         <= sum_d8;
                            ea_valid   <= 1'b1;
                            disp_ready <= 1'b0;
                            state      <= DONE;
                        end else begin
                            lo_q  <= disp_byte;
                            state <= DISP1;
                        end
                    end
                end
                DISP1: begin
                    if (disp_valid) begin
                        acc        <= sum_d16;
                        ea         <= sum_d16;
                        ea_valid   <= 1'b1;
                        disp_ready <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (ea_ready) begin
                        state    <= IDLE;
                        ea_valid <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modrm_ea_seq.sv
// Randomized self-checking bench for modrm_ea_seq against a table-driven
// EA model (register sums, displacement, read order, latency).
module tb_modrm_ea_seq;

    localparam int AW   = 16;
    localparam int NREG = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_modrm = '0;
    logic [NREG-1:0] rsel;
    logic [AW-1:0]   rdata;
    logic            disp_valid = 1'b0;
    logic            disp_ready;
    logic [7:0]      disp_byte = '0;
    logic            ea_valid;
    logic            ea_ready = 1'b0;
    logic [AW-1:0]   ea;
    logic            ea_is_reg;
    logic [2:0]      ea_rm;
`ifdef EA_SEG_SEL_EN
    logic            seg_ss;
`endif

    logic [15:0] regs [NREG];
    int checks = 0;
    int failures = 0;

    // rm -> base register number / index register number (-1 none)
    int base_tab [8] = '{8, 8, 4, 4, 2, 0, 4, 8};
    int idx_tab  [8] = '{2, 0, 2, 0, -1, -1, -1, -1};

    always #5 clk = ~clk;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NREG; i++)
            if (rsel[i]) rdata = rdata | regs[i];
    end

    modrm_ea_seq #(
        .AW(AW),
        .NREG(NREG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_modrm   (in_modrm),
        .rsel       (rsel),
        .rdata      (rdata),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_byte  (disp_byte),
        .ea_valid   (ea_valid),
        .ea_ready   (ea_ready),
        .ea         (ea),
        .ea_is_reg  (ea_is_reg),
`ifdef EA_SEG_SEL_EN
        .seg_ss     (seg_ss),
`endif
        .ea_rm      (ea_rm)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_regs();
        for (int i = 0; i < NREG; i++)
            regs[i] = 16'($urandom);
    endtask

    task automatic run_op(input logic [7:0] m,
                          input logic [7:0] b0,
                          input logic [7:0] b1,
                          input int gap,
                          input int hold);
        int mod, rm, nd, cyc, bi, gc, n, lat;
        int exp_sel[$];
        logic [15:0] got_sel[$];
        logic [15:0] e;
        logic seg_e;
        mod = int'(m[7:6]);
        rm  = int'(m[2:0]);
        e = 16'h0;
        nd = 0;
        if (mod != 3) begin
            if (!(mod == 0 && rm == 6)) begin
                exp_sel.push_back(base_tab[rm]);
                e = e + regs[base_tab[rm]];
                if (idx_tab[rm] >= 0) begin
                    exp_sel.push_back(idx_tab[rm]);
                    e = e + regs[idx_tab[rm]];
                end
            end
            if (mod == 1) nd = 1;
            else if (mod == 2) nd = 2;
            else if (rm == 6) nd = 2;
            if (nd == 1) e = e + {{8{b0[7]}}, b0};
            if (nd == 2) e = e + {b1, b0};
        end
        seg_e = (mod != 3) &&
                (rm == 2 || rm == 3 || (rm == 6 && mod != 0));
        lat = 1 + exp_sel.size() + nd * (1 + gap);

        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_modrm = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_modrm = 8'($urandom);
        cyc = 1;
        bi = 0;
        gc = gap;
        while (!ea_valid && cyc < 60) begin
            if (rsel != '0) got_sel.push_back(rsel);
            if (disp_ready) begin
                if (gc > 0) gc--;
                else begin
                    disp_valid = 1'b1;
                    disp_byte = (bi == 0) ? b0 : b1;
                    bi++;
                    gc = gap;
                end
            end
            @(posedge clk); #1;
            disp_valid = 1'b0;
            disp_byte = 8'($urandom);
            cyc++;
        end
        chk("ea_valid", 32'(ea_valid), 32'd1);
        chk("latency", 32'(cyc), 32'(lat));
        chk("rsel_count", 32'(got_sel.size()),
            32'(exp_sel.size()));
        for (int i = 0; i < got_sel.size() &&
             i < exp_sel.size(); i++)
            chk("rsel", 32'(got_sel[i]),
                32'(1) << exp_sel[i]);
        chk("ea", 32'(ea), 32'(e));
        chk("ea_is_reg", 32'(ea_is_reg), 32'(mod == 3));
        chk("ea_rm", 32'(ea_rm), 32'(rm));
        chk("in_ready_done", 32'(in_ready), 32'd0);
`ifdef EA_SEG_SEL_EN
        chk("seg_ss", 32'(seg_ss), 32'(seg_e));
`else
        seg_e = 1'b0;
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(ea_valid), 32'd1);
            chk("hold_ea", 32'(ea), 32'(e));
        end
        ea_ready = 1'b1;
        @(posedge clk); #1;
        ea_ready = 1'b0;
        chk("ea_drop", 32'(ea_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        rand_regs();
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rsel", 32'(rsel), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd0);
        chk("rst_ea_valid", 32'(ea_valid), 32'd0);
        chk("rst_ea", 32'(ea), 32'd0);
        chk("rst_ea_is_reg", 32'(ea_is_reg), 32'd0);
        chk("rst_ea_rm", 32'(ea_rm), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        regs[8] = 16'h1000;
        regs[2] = 16'h0020;
        run_op(8'h00, 8'h00, 8'h00, 0, 0);
        regs[4] = 16'h2000;
        run_op(8'h46, 8'hF0, 8'h00, 0, 0);
        run_op(8'h06, 8'h34, 8'h12, 2, 0);
        regs[4] = 16'hFFFF;
        regs[0] = 16'h0002;
        run_op(8'h83, 8'h01, 8'h00, 0, 1);
        run_op(8'hC5, 8'h00, 8'h00, 0, 5);
        run_op(8'h07, 8'h00, 8'h00, 0, 0);

        // flush while in DISP1 with a byte offered
        in_valid = 1'b1;
        in_modrm = 8'h86;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!disp_ready && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("flush_disp_ready", 32'(disp_ready), 32'd1);
        disp_valid = 1'b1;
        disp_byte = 8'h55;
        @(posedge clk); #1;
        flush = 1'b1;
        disp_byte = 8'h66;
        @(posedge clk); #1;
        flush = 1'b0;
        disp_valid = 1'b0;
        chk("flush_ea_valid", 32'(ea_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_disp_ready0", 32'(disp_ready), 32'd0);
        rand_regs();
        run_op(8'h81, 8'h10, 8'h20, 1, 0);

        // async reset while in INDEX
        regs[8] = 16'h1000;
        regs[2] = 16'h0020;
        in_valid = 1'b1;
        in_modrm = 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("index_rsel", 32'(rsel), 32'h0004);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_rsel", 32'(rsel), 32'd0);
        chk("arst_ea_valid", 32'(ea_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h00, 8'h00, 8'h00, 0, 0);

        for (int k = 0; k < 40; k++) begin
            rand_regs();
            run_op(8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
